spart_tx_param: RTL and testbench
=================================

# spart_tx_param

Parametrised SPART transmit channel: buffers bytes written from the processor-side bus in a small synchronous FIFO and serialises them on `txd` as asynchronous frames (start, data LSB-first, optional parity, 1 or 2 stop bits), paced by the shared baud-rate generator tick. It is the successor to the fixed 8-bit single-buffer transmitter in the SPART and adds a configurable data width, selectable parity, configurable stop bits, back-to-back frames and overflow detection.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

- `clk` in 1: clock.
- `rst` in 1: reset rst, synchronous, active-high.
- `baud_tick` in 1: one-cycle pulse per bit period from the BRG.
- `wr_en` in 1: write strobe; the byte is pushed when the FIFO is not full.
- `wr_data` in DATA_W: data to transmit.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `txd` out 1: serial output, registered, idles high.
- `tbr` out 1: transmit buffer ready; high when the FIFO is not full.
- `busy` out 1: high while a frame is on the line.
- `empty` out 1: high when the FIFO is empty and no frame is active.
- `overflow` out 1: sticky; set when `wr_en` arrives while the FIFO is full.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - On `baud_tick` with the FIFO non-empty: pop the head into the shift register.
  - Latch `parity_mode` at the same moment and compute the parity bit: even = ^data, odd = ~^data.
  - Go to START.
- START: `txd`=0 for one bit period.
- DATA
  - `txd` = shift[0], shifting right on each tick.
  - Bit counter runs 0..DATA_W-1.
- PARITY: entered only if the latched mode is even or odd; one bit period.
- STOP: `txd`=1 for STOP_BITS periods.
- End of the last stop bit:
  - If the FIFO is non-empty, pop the next entry and go directly to START. There is no idle gap.
  - Otherwise go to IDLE.
- All transitions occur only on `baud_tick`. Between ticks, state, counter and `txd` hold.
- Frame length is 1 + DATA_W + (parity?1:0) + STOP_BITS bit periods.
- FIFO
  - Push and pop in the same cycle are both honoured. When the FIFO is full, this is a legal write.
  - A write while full with no simultaneous pop is dropped, `overflow` is set, and FIFO contents are unchanged.
- Changing `parity_mode` mid-frame has no effect on the current frame.

## Timing
- Reset values: `txd`=1, `tbr`=1, `busy`=0, `empty`=1, `overflow`=0. On reset the FIFO pointers and count are cleared and the FSM goes to IDLE.
- Reset mid-frame: `txd` returns to 1 the cycle after `rst`, and any partial frame is abandoned.
- `tbr` and `empty` update the cycle after the push or pop that changes the FIFO count.
- Frame start latency:
  - Write at cycle N into an idle, empty channel: the entry is visible at N+1.
  - `txd` falls in the cycle after the first `baud_tick` at or after N+1.
- Each bit is held from the cycle after tick k through the cycle of tick k+1.
- `busy` rises with the falling edge of the start bit and falls the cycle after the tick that ends the final stop bit, unless the next frame starts.
- `baud_tick` on consecutive cycles is legal and advances one bit per tick.

## Structure
- Package `spart_pkg`:
  - Parity-mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD).
  - FSM state enum for the transmitter.
  - A shared frame-length function.
- Sub-module `spart_sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty). It is reused by the future RX path.
- The top level holds the FSM, the bit counter (width $clog2(DATA_W+1)), the shift register, the parity register and the overflow flag.

## Test plan
- Byte 0x55 at DATA_W=8, parity none, 1 stop, tick every 16 cycles → `txd` shows 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles; `busy` is high for 160 cycles.
- 0x07 with even parity, then with odd parity → parity bit 1, then 0. Frame is 11 bits.
- Write 0xA1, 0xB2, 0xC3 back-to-back → three contiguous frames with no idle bit between stop and start; `empty` rises after the third stop bit.
- FIFO_DEPTH=4 with no ticks and 5 writes → `tbr` falls after the 4th write; the 5th is dropped and `overflow`=1. Then 4 frames transmit with correct data.
- Assert `rst` during data bit 3 → `txd`=1 next cycle, `busy`=0, `empty`=1, `overflow`=0; the next write transmits a clean frame.
- DATA_W=7, STOP_BITS=2, odd parity, data 0x7F → frame 0,1111111,0,1,1 (11 bits).

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial channels: parity modes, transmitter
// states and frame helpers.
package spart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Bit periods per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input logic par_en,
                                              input int unsigned stop_bits);
        return 32'd1 + data_w + (par_en ? 32'd1 : 32'd0) + stop_bits;
    endfunction

    // Mode 2'b11 carries no parity bit, same as PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Data is zero-extended to 9 bits, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module spart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop & ~empty_r;
    assign push_ok_s = push & (~full_r | pop_ok_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == '0);
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/spart_tx_param.sv
// SPART transmit channel: FIFO-buffered writes serialised as start, LSB-first
// data, optional parity and stop bits, advancing one bit per baud_tick.
module spart_tx_param
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        parity_mode,
    output logic              txd,
    output logic              tbr,
    output logic              busy,
    output logic              empty,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_t         state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] shift_r, shift_nxt_s;
    logic              par_bit_r, par_bit_nxt_s;
    logic              par_en_r, par_en_nxt_s;
    logic              txd_r, txd_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              overflow_r;
    logic              load_s;
    logic              pop_s;
    logic [8:0]        data_ext_s;
    logic [DATA_W-1:0] fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    spart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop_s),
        .din   (wr_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Zero-extend the FIFO head for the shared parity helper.
    always_comb begin
        data_ext_s = 9'd0;
        data_ext_s[DATA_W-1:0] = fifo_dout_s;
    end

    // Next-state and datapath; nothing moves between ticks.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shift_nxt_s   = shift_r;
        par_bit_nxt_s = par_bit_r;
        par_en_nxt_s  = par_en_r;
        txd_nxt_s     = txd_r;
        busy_nxt_s    = busy_r;
        load_s        = 1'b0;
        pop_s         = 1'b0;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    load_s = ~fifo_empty_s;
                end
                START: begin
                    txd_nxt_s   = shift_r[0];
                    shift_nxt_s = shift_r >> 1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = DATA;
                end
                DATA: begin
                    if (cnt_r == DATA_LAST) begin
                        cnt_nxt_s = '0;
                        if (par_en_r) begin
                            txd_nxt_s   = par_bit_r;
                            state_nxt_s = PARITY;
                        end else begin
                            txd_nxt_s   = 1'b1;
                            state_nxt_s = STOP;
                        end
                    end else begin
                        txd_nxt_s   = shift_r[0];
                        shift_nxt_s = shift_r >> 1;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    txd_nxt_s   = 1'b1;
                    cnt_nxt_s   = '0;
                    state_nxt_s = STOP;
                end
                STOP: begin
                    if (cnt_r == STOP_LAST) begin
                        if (!fifo_empty_s) begin
                            load_s = 1'b1;
                        end else begin
                            txd_nxt_s   = 1'b1;
                            busy_nxt_s  = 1'b0;
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    txd_nxt_s   = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            load_s = 1'b0;
        end
        // Popping the head also latches the parity mode for the whole frame.
        if (load_s) begin
            pop_s         = 1'b1;
            shift_nxt_s   = fifo_dout_s;
            par_en_nxt_s  = parity_enabled(parity_mode);
            par_bit_nxt_s = parity_bit(data_ext_s, parity_mode);
            txd_nxt_s     = 1'b0;
            busy_nxt_s    = 1'b1;
            cnt_nxt_s     = '0;
            state_nxt_s   = START;
        end else begin
            pop_s = 1'b0;
        end
    end

    // State, datapath and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            par_en_r   <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            par_en_r   <= par_en_nxt_s;
            txd_r      <= txd_nxt_s;
            busy_r     <= busy_nxt_s;
            overflow_r <= overflow_r | (wr_en & fifo_full_s & ~pop_s);
        end
    end

    assign txd      = txd_r;
    assign tbr      = ~fifo_full_s;
    assign busy     = busy_r;
    assign empty    = fifo_empty_s & ~busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_spart_tx_param.sv
// Directed bench for spart_tx_param: 8-bit/1-stop instance plus a 7-bit/2-stop
// instance, frames sampled mid-bit against hand-computed bit patterns.
module tb_spart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [1:0] parity_mode = 2'b00;
    logic       txd, tbr, busy, empty, overflow;
    logic       wr_en7 = 1'b0;
    logic [6:0] wr_data7 = 7'd0;
    logic [1:0] parity_mode7 = 2'b00;
    logic       txd7, tbr7, busy7, empty7, overflow7;

    spart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en),
        .wr_data(wr_data), .parity_mode(parity_mode), .txd(txd), .tbr(tbr),
        .busy(busy), .empty(empty), .overflow(overflow)
    );

    spart_tx_param #(.DATA_W(7), .FIFO_DEPTH(4), .STOP_BITS(2)) dut7 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en7),
        .wr_data(wr_data7), .parity_mode(parity_mode7), .txd(txd7), .tbr(tbr7),
        .busy(busy7), .empty(empty7), .overflow(overflow7)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 16;
    bit tick_en = 1'b1;
    int tick_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  pm;
        logic [15:0] frame;
        int          len;
    } vec_t;
    vec_t vecs[6];

    // Baud generator stand-in, driven away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_en && tick_cnt >= tick_div - 1) begin
                baud_tick = 1'b1;
                tick_cnt  = 0;
            end else begin
                baud_tick = 1'b0;
                if (tick_en) tick_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic txd_sel(input bit s);
        return s ? txd7 : txd;
    endfunction

    function automatic logic busy_sel(input bit s);
        return s ? busy7 : busy;
    endfunction

    function automatic logic empty_sel(input bit s);
        return s ? empty7 : empty;
    endfunction

    // Line-bit model: start, LSB-first data, optional parity, stop bits.
    function automatic logic [15:0] exp_frame(input logic [8:0] d, input int dw,
                                              input logic [1:0] pm, input int sb);
        logic [15:0] f = '0;
        int n = 1;
        logic p = 1'b0;
        for (int i = 0; i < dw; i++) begin
            f[n] = d[i];
            p = p ^ d[i];
            n++;
        end
        if (pm == 2'b01) begin
            f[n] = p;
            n++;
        end else if (pm == 2'b10) begin
            f[n] = ~p;
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            f[n] = 1'b1;
            n++;
        end
        return f;
    endfunction

    function automatic int exp_len(input int dw, input logic [1:0] pm, input int sb);
        return 1 + dw + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + sb;
    endfunction

    task automatic write8(input logic [7:0] d, input logic [1:0] pm);
        wr_data = d;
        parity_mode = pm;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_low(input string name);
        int waited = 0;
        while (txd !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: start bit never appeared within 200 cycles", name);
        end
    endtask

    // Finds the start bit, samples every bit mid-period and counts busy cycles.
    task automatic check_frame(input bit sel, input logic [15:0] frame, input int len,
                               input int per, input string name,
                               input bit contiguous, input bit idle_after);
        int waited = 0;
        int busy_cnt = 0;
        while (txd_sel(sel) !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: start bit never appeared within 400 cycles", name);
            return;
        end
        if (contiguous) chk({name, "_gap"}, waited, 0);
        for (int c = 0; c < len * per; c++) begin
            if (busy_sel(sel)) busy_cnt++;
            if (c % per == per / 2)
                chk($sformatf("%s_bit%0d", name, c / per), {31'd0, txd_sel(sel)}, {31'd0, frame[c / per]});
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, busy_cnt, len * per);
        if (idle_after) begin
            chk({name, "_busy_end"}, {31'd0, busy_sel(sel)}, 32'd0);
            chk({name, "_empty_end"}, {31'd0, empty_sel(sel)}, 32'd1);
            chk({name, "_txd_idle"}, {31'd0, txd_sel(sel)}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] b2b[3];
        logic [7:0] ovf[4];

        vecs[0] = '{8'h55, 2'b00, 16'h02AA, 10};
        vecs[1] = '{8'h07, 2'b01, 16'h060E, 11};
        vecs[2] = '{8'h07, 2'b10, 16'h040E, 11};
        vecs[3] = '{8'hC3, 2'b11, 16'h0386, 10};
        vecs[4] = '{8'h00, 2'b10, 16'h0600, 11};
        vecs[5] = '{8'hFF, 2'b01, 16'h05FE, 11};
        b2b = '{8'hA1, 8'hB2, 8'hC3};
        ovf = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tbr", {31'd0, tbr}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_txd7", {31'd0, txd7}, 32'd1);
        chk("rst_empty7", {31'd0, empty7}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            write8(vecs[v].data, vecs[v].pm);
            check_frame(1'b0, vecs[v].frame, vecs[v].len, 16, $sformatf("vec%0d", v), 1'b0, 1'b1);
        end

        // Consecutive ticks: write at N, txd falls at N+2, one bit per cycle.
        tick_div = 1;
        repeat (3) @(negedge clk);
        write8(8'hA1, 2'b01);
        chk("lat_pre", {31'd0, txd}, 32'd1);
        @(negedge clk);
        chk("lat_fall", {31'd0, txd}, 32'd0);
        check_frame(1'b0, 16'h0742, 11, 1, "fast", 1'b1, 1'b1);
        tick_div = 16;
        repeat (20) @(negedge clk);

        // Parity mode changed after the frame starts must not matter.
        write8(8'h07, 2'b01);
        wait_low("par_hold_start");
        parity_mode = 2'b10;
        check_frame(1'b0, 16'h060E, 11, 16, "par_hold", 1'b0, 1'b1);

        // Three queued bytes go out with no idle bit between frames.
        tick_en = 1'b0;
        for (int i = 0; i < 3; i++) write8(b2b[i], 2'b00);
        tick_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_frame(1'b0, exp_frame({1'b0, b2b[i]}, 8, 2'b00, 1), exp_len(8, 2'b00, 1), 16,
                        $sformatf("b2b%0d", i), i > 0, i == 2);
            if (i < 2) chk($sformatf("b2b%0d_empty_mid", i), {31'd0, empty}, 32'd0);
        end

        // Fill the FIFO with ticks halted, then overflow it.
        tick_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write8(ovf[i], 2'b01);
            chk($sformatf("ovf_tbr%0d", i), {31'd0, tbr}, (i == 3) ? 32'd0 : 32'd1);
        end
        chk("ovf_flag_pre", {31'd0, overflow}, 32'd0);
        write8(8'h99, 2'b01);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_tbr_full", {31'd0, tbr}, 32'd0);
        tick_en = 1'b1;
        for (int i = 0; i < 4; i++)
            check_frame(1'b0, exp_frame({1'b0, ovf[i]}, 8, 2'b01, 1), exp_len(8, 2'b01, 1), 16,
                        $sformatf("ovf_frame%0d", i), i > 0, i == 3);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of data bit 3.
        write8(8'h96, 2'b00);
        wait_low("rst_mid_start");
        repeat (4 * 16 + 8) @(negedge clk);
        chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd", {31'd0, txd}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_empty", {31'd0, empty}, 32'd1);
        chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_mid_quiet", {31'd0, txd}, 32'd1);
        write8(8'h3C, 2'b00);
        check_frame(1'b0, exp_frame(9'h03C, 8, 2'b00, 1), 10, 16, "post_rst", 1'b0, 1'b1);

        // 7 data bits, odd parity, two stop bits.
        wr_data7 = 7'h7F;
        parity_mode7 = 2'b10;
        wr_en7 = 1'b1;
        @(negedge clk);
        wr_en7 = 1'b0;
        check_frame(1'b1, 16'h06FE, 11, 16, "w7", 1'b0, 1'b1);
        chk("w7_tbr", {31'd0, tbr7}, 32'd1);
        chk("w7_overflow", {31'd0, overflow7}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
